gx_rst_ctrl: RTL and testbench
==============================

GX_RST_CTRL -- requirements
Module: gx_rst_ctrl

Interface
REQ-001 Parameter NUM_CH, default 5: number of transceiver channels sequenced.
REQ-002 Parameter T_ANALOG, default 70: analog reset hold, in clk cycles.
REQ-003 Parameter T_DIGITAL, default 20: digital reset hold after lock, in clk cycles.
REQ-004 Parameter T_LTD, default 400: required continuous rx_is_lockedtodata high time, in clk cycles.
REQ-005 Parameter LOCK_TIMEOUT, default 100000: maximum wait for lock-to-data, in clk cycles.
REQ-006 Port clk, input, 1 bit: sole clock for all logic.
REQ-007 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port tx_pll_locked, input, 1 bit: TX PLL lock (asynchronous).
REQ-009 Port tx_cal_busy and rx_cal_busy, inputs, NUM_CH bits each: per-channel calibration in progress (asynchronous).
REQ-010 Port rx_is_lockedtodata, input, NUM_CH bits: per-channel CDR lock-to-data (asynchronous).
REQ-011 Port tx_rst_req, input, 1 bit: soft TX reset request, level, synchronous to clk.
REQ-012 Port rx_rst_req, input, NUM_CH bits: per-channel soft RX reset request, level, synchronous to clk.
REQ-013 Ports tx_analogreset and tx_digitalreset, outputs, NUM_CH bits each: TX resets to the transceiver.
REQ-014 Ports rx_analogreset and rx_digitalreset, outputs, NUM_CH bits each: RX resets to the transceiver.
REQ-015 Port tx_ready, output, 1 bit: TX is out of reset and stable.
REQ-016 Port rx_ready, output, NUM_CH bits: per-channel RX is out of reset and stable.

Function
REQ-017 All asynchronous inputs (REQ-008 to REQ-010) SHALL pass through 2-FF synchronizers; everything downstream SHALL see 2 cycles of latency.
REQ-018 The TX path is bonded: one TX FSM SHALL drive all NUM_CH bits of tx_analogreset and tx_digitalreset identically.
REQ-019 TX FSM states and actions:
- TX_ANA: assert analog and digital reset for T_ANALOG cycles, then go to TX_WAIT.
- TX_WAIT: analog reset low, digital reset high; wait for sync tx_pll_locked=1 and all tx_cal_busy=0, then go to TX_DIG.
- TX_DIG: digital reset high for T_DIGITAL cycles, then go to TX_RDY.
- TX_RDY: both resets low; tx_ready=1.
REQ-020 In any TX state, tx_rst_req=1 or loss of sync tx_pll_locked SHALL force TX_ANA with its counter cleared on the next cycle.
REQ-021 One RX FSM per channel SHALL run independently of TX and of the other channels.
REQ-022 RX FSM states and actions:
- RX_ANA: assert analog and digital reset for T_ANALOG cycles, then go to RX_CAL.
- RX_CAL: digital reset only; wait for rx_cal_busy=0, then go to RX_LTD.
- RX_LTD: digital reset only; wait for rx_is_lockedtodata high for T_LTD consecutive cycles (any low clears the stability counter), then go to RX_DIG.
- RX_DIG: digital reset only, for T_DIGITAL cycles, then go to RX_RDY.
- RX_RDY: both resets low; rx_ready=1.
REQ-023 RX timeout: LOCK_TIMEOUT cycles spent in RX_LTD without meeting the lock condition SHALL return the FSM to RX_ANA.
REQ-024 In RX_RDY, rx_is_lockedtodata=0 SHALL assert rx_digitalreset, clear rx_ready, and return to RX_LTD on the next cycle (analog reset stays low).
REQ-025 rx_rst_req[i]=1 in any state SHALL force RX_ANA with counters cleared; it takes priority over timeout and lock loss in the same cycle.
REQ-026 A held request SHALL keep the FSM in *_ANA; counting starts on the first cycle after the request drops.
REQ-027 tx_ready and rx_ready SHALL be registered and SHALL equal 1 exactly when the corresponding FSM is in *_RDY.
REQ-028 Counters SHALL be sized from clog2 of the largest parameter, SHALL NOT wrap, and SHALL clear on every state entry.

Reset
REQ-029 Asserting reset_n low SHALL immediately set all reset outputs to 1, all ready outputs to 0, all FSMs to *_ANA, and counters and synchronizers to 0; this applies equally mid-sequence.
REQ-030 Release of reset_n SHALL start the T_ANALOG count on the first clk edge after release.

Configuration
REQ-031 Macro GX_RST_RETRY_CNT_EN, when defined: adds output rx_retry_cnt (NUM_CH x 8 bits), a per-channel count of REQ-023 timeouts, saturating at 255 and cleared only by reset_n.
REQ-032 Without GX_RST_RETRY_CNT_EN: the port and its counters SHALL be absent, with FSM behaviour identical.

Structure
REQ-033 Package gx_rst_pkg SHALL hold the TX and RX state enums and the counter-width function/constant.
REQ-034 The RX FSM SHALL be sub-module gx_rx_rst_fsm, instantiated NUM_CH times by generate; TX FSM and synchronizers stay in the top.

Verification
REQ-035 After reset release with tx_pll_locked=1 and cal_busy=0: tx_analogreset falls at cycle 70+1, tx_ready rises after 70+2+20 (±1), and all rx_ready bits rise after the lock is stable for 400 cycles.
REQ-036 With rx_cal_busy[2]=1 held for 1000 cycles: only channel 2 stays in RX_CAL; the other channels reach rx_ready.
REQ-037 With rx_is_lockedtodata[0] never high and LOCK_TIMEOUT=1000: rx_analogreset[0] re-pulses every ~1000+70 cycles, and with the macro rx_retry_cnt[0] increments each time.
REQ-038 Drop rx_is_lockedtodata[1] for 5 cycles while in RX_RDY: rx_digitalreset[1]=1, rx_analogreset[1] stays 0, and rx_ready[1] returns 400+20 cycles after the lock recovers.
REQ-039 Drop tx_pll_locked mid-RX_DIG, and separately pulse reset_n low for 1 cycle: all TX resets assert within 3 cycles, and the full sequence replays from the start.

Source files
------------

// File: rtl/gx_rst_pkg.sv
// -----------------------------------------------------------------------------
// gx_rst_pkg
// Shared types and helpers for the transceiver reset controller.
//   tx_state_e  : bonded TX reset sequencer states
//   rx_state_e  : per-channel RX reset sequencer states
//   RETRY_W     : width of the optional per-channel lock-timeout retry counter
//   cnt_width() : counter width able to hold the largest timing parameter
// Optional feature macro used by the importing files: GX_RST_RETRY_CNT_EN.
// -----------------------------------------------------------------------------
package gx_rst_pkg;

  typedef enum logic [1:0] {
    TX_ANA  = 2'd0,
    TX_WAIT = 2'd1,
    TX_DIG  = 2'd2,
    TX_RDY  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_ANA = 3'd0,
    RX_CAL = 3'd1,
    RX_LTD = 3'd2,
    RX_DIG = 3'd3,
    RX_RDY = 3'd4
  } rx_state_e;

  localparam int RETRY_W = 8;

  // Width of a counter that must reach the largest of the four timing values.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gx_rx_rst_fsm.sv
// -----------------------------------------------------------------------------
// gx_rx_rst_fsm
// Reset sequencer for one RX channel:
//   RX_ANA -> RX_CAL -> RX_LTD -> RX_DIG -> RX_RDY
// Inputs cal_busy_i / ltd_i must already be synchronized to clk_i.
// Ports:
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   cal_busy_i          : RX calibration busy (synchronized)
//   ltd_i               : CDR locked-to-data (synchronized)
//   rst_req_i           : soft reset request, level, synchronous
//   ana_rst_o/dig_rst_o : registered analog / digital reset
//   ready_o             : registered, high exactly in RX_RDY
//   retry_cnt_o         : saturating lock-timeout count (only with
//                         GX_RST_RETRY_CNT_EN defined)
// -----------------------------------------------------------------------------
module gx_rx_rst_fsm
  import gx_rst_pkg::*;
#(
  parameter int T_ANALOG     = 70,
  parameter int T_DIGITAL    = 20,
  parameter int T_LTD        = 400,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               cal_busy_i,
  input  logic               ltd_i,
  input  logic               rst_req_i,
`ifdef GX_RST_RETRY_CNT_EN
  output logic [RETRY_W-1:0] retry_cnt_o,
`endif
  output logic               ana_rst_o,
  output logic               dig_rst_o,
  output logic               ready_o
);

  localparam int CNT_W = cnt_width(T_ANALOG, T_DIGITAL, T_LTD, LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(T_ANALOG - 1);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(T_DIGITAL - 1);
  localparam logic [CNT_W-1:0] LTD_LAST = CNT_W'(T_LTD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;    // dwell time in current state
  logic [CNT_W-1:0] stab_q, stab_d;  // consecutive locked cycles in RX_LTD
  logic             timeout;
  logic             ana_q, ana_d;
  logic             dig_q, dig_d;
  logic             rdy_q, rdy_d;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RX_ANA;
      cnt_q   <= '0;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    stab_d  = '0;
    timeout = 1'b0;
    case (state_q)
      RX_ANA: if (cnt_q == ANA_LAST) state_d = RX_CAL;
      RX_CAL: if (!cal_busy_i) state_d = RX_LTD;
      RX_LTD: begin
        if (ltd_i) begin
          if (stab_q == LTD_LAST) state_d = RX_DIG;
          else                    stab_d  = stab_q + 1'b1;
        end
        // Meeting the lock condition wins over an expiring timeout.
        if (state_d == RX_LTD && cnt_q == TMO_LAST) begin
          state_d = RX_ANA;
          timeout = 1'b1;
        end
      end
      RX_DIG: if (cnt_q == DIG_LAST) state_d = RX_RDY;
      RX_RDY: if (!ltd_i) state_d = RX_LTD;
      default: state_d = RX_ANA;
    endcase
    // Soft request overrides everything, and a held request pins the counter at 0.
    if (rst_req_i) begin
      state_d = RX_ANA;
      timeout = 1'b0;
    end
    if (rst_req_i || state_d != state_q) begin
      cnt_d  = '0;
      stab_d = '0;
    end
  end

  // Output logic, decoded from the next state so the registered outputs track state_q
  always_comb begin
    ana_d = (state_d == RX_ANA);
    dig_d = (state_d != RX_RDY);
    rdy_d = (state_d == RX_RDY);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ana_q <= 1'b1;
      dig_q <= 1'b1;
      rdy_q <= 1'b0;
    end else begin
      ana_q <= ana_d;
      dig_q <= dig_d;
      rdy_q <= rdy_d;
    end
  end

  assign ana_rst_o = ana_q;
  assign dig_rst_o = dig_q;
  assign ready_o   = rdy_q;

`ifdef GX_RST_RETRY_CNT_EN
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_comb begin
    retry_d = retry_q;
    if (timeout && retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) retry_q <= '0;
    else            retry_q <= retry_d;
  end

  assign retry_cnt_o = retry_q;
`endif

endmodule

// File: rtl/gx_rst_ctrl.sv
// -----------------------------------------------------------------------------
// gx_rst_ctrl
// Transceiver reset controller: one bonded TX sequencer plus NUM_CH
// independent RX sequencers (gx_rx_rst_fsm).
// Optional feature macro: GX_RST_RETRY_CNT_EN adds rx_retry_cnt.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   tx_pll_locked           : TX PLL lock (async, synchronized here)
//   tx_cal_busy/rx_cal_busy : per-channel calibration busy (async)
//   rx_is_lockedtodata      : per-channel CDR lock-to-data (async)
//   tx_rst_req, rx_rst_req  : soft reset requests (level, synchronous)
//   tx_analogreset/tx_digitalreset : bonded TX resets (all bits equal)
//   rx_analogreset/rx_digitalreset : per-channel RX resets
//   tx_ready, rx_ready      : registered ready flags
//   rx_retry_cnt            : NUM_CH x 8-bit lock-timeout counts (macro only)
// -----------------------------------------------------------------------------
module gx_rst_ctrl
  import gx_rst_pkg::*;
#(
  parameter int NUM_CH       = 5,
  parameter int T_ANALOG     = 70,
  parameter int T_DIGITAL    = 20,
  parameter int T_LTD        = 400,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tx_pll_locked,
  input  logic [NUM_CH-1:0]           tx_cal_busy,
  input  logic [NUM_CH-1:0]           rx_cal_busy,
  input  logic [NUM_CH-1:0]           rx_is_lockedtodata,
  input  logic                        tx_rst_req,
  input  logic [NUM_CH-1:0]           rx_rst_req,
  output logic [NUM_CH-1:0]           tx_analogreset,
  output logic [NUM_CH-1:0]           tx_digitalreset,
  output logic [NUM_CH-1:0]           rx_analogreset,
  output logic [NUM_CH-1:0]           rx_digitalreset,
  output logic                        tx_ready,
`ifdef GX_RST_RETRY_CNT_EN
  output logic [NUM_CH*RETRY_W-1:0]   rx_retry_cnt,
`endif
  output logic [NUM_CH-1:0]           rx_ready
);

  localparam int CNT_W  = cnt_width(T_ANALOG, T_DIGITAL, T_LTD, LOCK_TIMEOUT);
  localparam int SYNC_W = 1 + 3 * NUM_CH;
  localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(T_ANALOG - 1);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(T_DIGITAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Two-flop synchronizers for every asynchronous status input
  logic [SYNC_W-1:0] async_in, meta_q, sync_q;
  logic              pll_s;
  logic [NUM_CH-1:0] tx_cal_s, rx_cal_s, ltd_s;

  assign async_in = {tx_pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign pll_s    = sync_q[SYNC_W-1];
  assign tx_cal_s = sync_q[3*NUM_CH-1 -: NUM_CH];
  assign rx_cal_s = sync_q[2*NUM_CH-1 -: NUM_CH];
  assign ltd_s    = sync_q[NUM_CH-1:0];

  // TX sequencer: loss of lock is the falling edge of the synchronized PLL
  // lock, so waiting for a lock that never came does not retrigger TX_ANA.
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             pll_prev_q;
  logic             pll_fall;
  logic             tx_ana_q, tx_ana_d;
  logic             tx_dig_q, tx_dig_d;
  logic             tx_rdy_q, tx_rdy_d;

  assign pll_fall = pll_prev_q & ~pll_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_ANA;
      tx_cnt_q   <= '0;
      pll_prev_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      pll_prev_q <= pll_s;
    end
  end

  // Next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == CNT_MAX) ? tx_cnt_q : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_ANA:  if (tx_cnt_q == ANA_LAST) tx_state_d = TX_WAIT;
      TX_WAIT: if (pll_s && !(|tx_cal_s)) tx_state_d = TX_DIG;
      TX_DIG:  if (tx_cnt_q == DIG_LAST) tx_state_d = TX_RDY;
      TX_RDY:  tx_state_d = TX_RDY;
      default: tx_state_d = TX_ANA;
    endcase
    if (tx_rst_req || pll_fall) tx_state_d = TX_ANA;
    if (tx_rst_req || pll_fall || tx_state_d != tx_state_q) tx_cnt_d = '0;
  end

  // Output logic
  always_comb begin
    tx_ana_d = (tx_state_d == TX_ANA);
    tx_dig_d = (tx_state_d != TX_RDY);
    tx_rdy_d = (tx_state_d == TX_RDY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ana_q <= 1'b1;
      tx_dig_q <= 1'b1;
      tx_rdy_q <= 1'b0;
    end else begin
      tx_ana_q <= tx_ana_d;
      tx_dig_q <= tx_dig_d;
      tx_rdy_q <= tx_rdy_d;
    end
  end

  assign tx_analogreset  = {NUM_CH{tx_ana_q}};
  assign tx_digitalreset = {NUM_CH{tx_dig_q}};
  assign tx_ready        = tx_rdy_q;

  // Independent RX sequencers
  for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
    gx_rx_rst_fsm #(
      .T_ANALOG     (T_ANALOG),
      .T_DIGITAL    (T_DIGITAL),
      .T_LTD        (T_LTD),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_rx_fsm (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .cal_busy_i  (rx_cal_s[i]),
      .ltd_i       (ltd_s[i]),
      .rst_req_i   (rx_rst_req[i]),
`ifdef GX_RST_RETRY_CNT_EN
      .retry_cnt_o (rx_retry_cnt[i*RETRY_W +: RETRY_W]),
`endif
      .ana_rst_o   (rx_analogreset[i]),
      .dig_rst_o   (rx_digitalreset[i]),
      .ready_o     (rx_ready[i])
    );
  end

endmodule

// File: tb/tb_gx_rst_ctrl.sv
module tb_gx_rst_ctrl;

  localparam int NCH = 5;
  localparam logic [NCH-1:0] ALL = '1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           tx_pll_locked = 1'b1;
  logic [NCH-1:0] tx_cal_busy = '0;
  logic [NCH-1:0] rx_cal_busy = '0;
  logic [NCH-1:0] rx_ltd = '1;
  logic           tx_rst_req = 1'b0;
  logic [NCH-1:0] rx_rst_req = '0;
  logic [NCH-1:0] tx_ana, tx_dig, rx_ana, rx_dig, rx_ready;
  logic           tx_ready;
`ifdef GX_RST_RETRY_CNT_EN
  logic [NCH*8-1:0] rx_retry_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gx_rst_ctrl #(
    .NUM_CH(NCH), .T_ANALOG(70), .T_DIGITAL(20), .T_LTD(400), .LOCK_TIMEOUT(1000)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .tx_pll_locked      (tx_pll_locked),
    .tx_cal_busy        (tx_cal_busy),
    .rx_cal_busy        (rx_cal_busy),
    .rx_is_lockedtodata (rx_ltd),
    .tx_rst_req         (tx_rst_req),
    .rx_rst_req         (rx_rst_req),
    .tx_analogreset     (tx_ana),
    .tx_digitalreset    (tx_dig),
    .rx_analogreset     (rx_ana),
    .rx_digitalreset    (rx_dig),
    .tx_ready           (tx_ready),
`ifdef GX_RST_RETRY_CNT_EN
    .rx_retry_cnt       (rx_retry_cnt),
`endif
    .rx_ready           (rx_ready)
  );

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Puts the DUT through reset; edge k after return is the k-th edge after release.
  task automatic apply_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx_ana !== ALL) begin bad++; $display("FAIL rst_tx_ana: got %b expected %b", tx_ana, ALL); end
    total++; if (tx_dig !== ALL) begin bad++; $display("FAIL rst_tx_dig: got %b expected %b", tx_dig, ALL); end
    total++; if (rx_ana !== ALL) begin bad++; $display("FAIL rst_rx_ana: got %b expected %b", rx_ana, ALL); end
    total++; if (rx_dig !== ALL) begin bad++; $display("FAIL rst_rx_dig: got %b expected %b", rx_dig, ALL); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready: got %b expected 0", tx_ready); end
    total++; if (rx_ready !== '0) begin bad++; $display("FAIL rst_rx_ready: got %b expected 00000", rx_ready); end
    edges(3);
    total++; if (tx_ana !== ALL || tx_ready !== 1'b0) begin bad++; $display("FAIL rst_hold: got ana=%b rdy=%b expected ana=%b rdy=0", tx_ana, tx_ready, ALL); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_powerup();
    int fa = 0, fr = 0, ra = 0, rr = 0, rany = 0;
    logic [NCH-1:0] dig_at_fa = '0;
    for (int k = 1; k <= 600; k++) begin
      edges(1);
      if (fa == 0 && tx_ana == '0) begin fa = k; dig_at_fa = tx_dig; end
      if (fr == 0 && tx_ready) fr = k;
      if (ra == 0 && rx_ana == '0) ra = k;
      if (rany == 0 && rx_ready != '0) rany = k;
      if (rr == 0 && rx_ready == ALL) rr = k;
    end
    total++; if (fa < 70 || fa > 72) begin bad++; $display("FAIL pu_tx_ana_fall: got edge %0d expected 70..72", fa); end
    total++; if (dig_at_fa !== ALL) begin bad++; $display("FAIL pu_tx_dig_held: got %b expected %b", dig_at_fa, ALL); end
    total++; if (fr < 91 || fr > 93) begin bad++; $display("FAIL pu_tx_ready: got edge %0d expected 91..93", fr); end
    total++; if (ra < 70 || ra > 72) begin bad++; $display("FAIL pu_rx_ana_fall: got edge %0d expected 70..72", ra); end
    total++; if (rr < 490 || rr > 494) begin bad++; $display("FAIL pu_rx_ready: got edge %0d expected 490..494", rr); end
    total++; if (rany !== rr) begin bad++; $display("FAIL pu_rx_ready_together: got first-any %0d expected %0d", rany, rr); end
  endtask

  task automatic test_cal_busy();
    int r2 = 0;
    rx_cal_busy = 5'b00100;
    apply_reset();
    edges(1000);
    total++; if (rx_ready !== 5'b11011) begin bad++; $display("FAIL cal_rx_ready: got %b expected 11011", rx_ready); end
    total++; if (rx_ana[2] !== 1'b0 || rx_dig[2] !== 1'b1) begin bad++; $display("FAIL cal_ch2_resets: got ana=%b dig=%b expected ana=0 dig=1", rx_ana[2], rx_dig[2]); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL cal_tx_ready: got %b expected 1", tx_ready); end
    rx_cal_busy = '0;
    for (int k = 1; k <= 440; k++) begin
      edges(1);
      if (r2 == 0 && rx_ready[2]) r2 = k;
    end
    total++; if (r2 < 420 || r2 > 426) begin bad++; $display("FAIL cal_ch2_ready: got edge %0d expected 420..426", r2); end
  endtask

  task automatic test_lock_loss();
    int back = 0;
    logic dig3 = 1'b0, rdy3 = 1'b1, ana_seen = 1'b0, others_lost = 1'b0;
    rx_ltd[1] = 1'b0;
    for (int k = 1; k <= 440; k++) begin
      edges(1);
      if (k == 3) begin dig3 = rx_dig[1]; rdy3 = rx_ready[1]; end
      if (k == 5) rx_ltd[1] = 1'b1;
      if (rx_ana[1]) ana_seen = 1'b1;
      if ((rx_ready & 5'b11101) != 5'b11101) others_lost = 1'b1;
      if (k > 3 && back == 0 && rx_ready[1]) back = k;
    end
    total++; if (dig3 !== 1'b1 || rdy3 !== 1'b0) begin bad++; $display("FAIL ll_dig_assert: got dig=%b rdy=%b expected dig=1 rdy=0", dig3, rdy3); end
    total++; if (ana_seen !== 1'b0) begin bad++; $display("FAIL ll_ana_low: got %b expected 0", ana_seen); end
    total++; if (others_lost !== 1'b0) begin bad++; $display("FAIL ll_others: got %b expected 0", others_lost); end
    total++; if (back < 423 || back > 431) begin bad++; $display("FAIL ll_ready_back: got edge %0d expected 423..431", back); end
  endtask

  task automatic test_timeout();
    int rises = 0, r1 = 0, r2 = 0;
    logic prev = 1'b0, others_lost = 1'b0;
    rx_ltd[0] = 1'b0;
    for (int k = 1; k <= 2300; k++) begin
      edges(1);
      if (rx_ana[0] && !prev) begin
        rises++;
        if (rises == 1) r1 = k;
        if (rises == 2) r2 = k;
      end
      prev = rx_ana[0];
      if (rx_ready[4:1] != 4'hF) others_lost = 1'b1;
    end
    total++; if (rises !== 2) begin bad++; $display("FAIL to_rises: got %0d expected 2", rises); end
    total++; if (r1 < 1000 || r1 > 1008) begin bad++; $display("FAIL to_first: got edge %0d expected 1000..1008", r1); end
    total++; if (r2 - r1 < 1065 || r2 - r1 > 1077) begin bad++; $display("FAIL to_period: got %0d expected 1065..1077", r2 - r1); end
    total++; if (others_lost !== 1'b0) begin bad++; $display("FAIL to_others: got %b expected 0", others_lost); end
`ifdef GX_RST_RETRY_CNT_EN
    total++; if (rx_retry_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL to_retry0: got %0d expected 2", rx_retry_cnt[7:0]); end
    total++; if (rx_retry_cnt[39:8] !== '0) begin bad++; $display("FAIL to_retry_others: got %h expected 0", rx_retry_cnt[39:8]); end
`endif
    rx_ltd[0] = 1'b1;
    edges(450);
    total++; if (rx_ready !== ALL) begin bad++; $display("FAIL to_recover: got %b expected %b", rx_ready, ALL); end
  endtask

  task automatic test_rx_req();
    rx_rst_req[3] = 1'b1;
    edges(1);
    total++; if (rx_ana[3] !== 1'b1 || rx_dig[3] !== 1'b1 || rx_ready[3] !== 1'b0) begin bad++; $display("FAIL rq_rx_assert: got ana=%b dig=%b rdy=%b expected 1 1 0", rx_ana[3], rx_dig[3], rx_ready[3]); end
    edges(9);
    total++; if (rx_ana[3] !== 1'b1) begin bad++; $display("FAIL rq_rx_held: got %b expected 1", rx_ana[3]); end
    rx_rst_req[3] = 1'b0;
    edges(69);
    total++; if (rx_ana[3] !== 1'b1) begin bad++; $display("FAIL rq_rx_ana69: got %b expected 1", rx_ana[3]); end
    edges(2);
    total++; if (rx_ana[3] !== 1'b0) begin bad++; $display("FAIL rq_rx_ana71: got %b expected 0", rx_ana[3]); end
    edges(425);
    total++; if (rx_ready !== ALL) begin bad++; $display("FAIL rq_rx_ready: got %b expected %b", rx_ready, ALL); end
  endtask

  task automatic test_tx_req();
    tx_rst_req = 1'b1;
    edges(1);
    total++; if (tx_ana !== ALL || tx_ready !== 1'b0) begin bad++; $display("FAIL rq_tx_assert: got ana=%b rdy=%b expected %b 0", tx_ana, tx_ready, ALL); end
    edges(4);
    tx_rst_req = 1'b0;
    edges(69);
    total++; if (tx_ana !== ALL) begin bad++; $display("FAIL rq_tx_ana69: got %b expected %b", tx_ana, ALL); end
    edges(2);
    total++; if (tx_ana !== '0 || tx_dig !== ALL) begin bad++; $display("FAIL rq_tx_ana71: got ana=%b dig=%b expected 00000 11111", tx_ana, tx_dig); end
    edges(22);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rq_tx_ready: got %b expected 1", tx_ready); end
    total++; if (rx_ready !== ALL) begin bad++; $display("FAIL rq_tx_rx_undisturbed: got %b expected %b", rx_ready, ALL); end
  endtask

  task automatic test_pll_drop();
    int fa = 0, fr = 0;
    apply_reset();
    edges(480);
    total++; if (rx_dig !== ALL || rx_ana !== '0 || rx_ready !== '0) begin bad++; $display("FAIL pd_mid_dig: got ana=%b dig=%b rdy=%b expected 00000 11111 00000", rx_ana, rx_dig, rx_ready); end
    tx_pll_locked = 1'b0;
    edges(3);
    total++; if (tx_ana !== ALL || tx_dig !== ALL || tx_ready !== 1'b0) begin bad++; $display("FAIL pd_tx_assert: got ana=%b dig=%b rdy=%b expected %b %b 0", tx_ana, tx_dig, tx_ready, ALL, ALL); end
    edges(2);
    tx_pll_locked = 1'b1;
    for (int k = 6; k <= 120; k++) begin
      edges(1);
      if (fa == 0 && tx_ana == '0) fa = k;
      if (fr == 0 && tx_ready) fr = k;
    end
    total++; if (fa < 71 || fa > 76) begin bad++; $display("FAIL pd_tx_ana_fall: got %0d expected 71..76", fa); end
    total++; if (fr < 91 || fr > 97) begin bad++; $display("FAIL pd_tx_ready: got %0d expected 91..97", fr); end
    total++; if (rx_ready !== ALL) begin bad++; $display("FAIL pd_rx_ready: got %b expected %b", rx_ready, ALL); end
  endtask

  task automatic test_reset_pulse();
    int fa = 0, fr = 0, rr = 0;
    @(negedge clk) reset_n = 1'b0;
    #1;
    total++; if (tx_ana !== ALL || rx_ana !== ALL || rx_dig !== ALL) begin bad++; $display("FAIL rp_resets: got tx=%b rxa=%b rxd=%b expected all ones", tx_ana, rx_ana, rx_dig); end
    total++; if (tx_ready !== 1'b0 || rx_ready !== '0) begin bad++; $display("FAIL rp_ready: got tx=%b rx=%b expected 0", tx_ready, rx_ready); end
    @(negedge clk) reset_n = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      edges(1);
      if (fa == 0 && tx_ana == '0) fa = k;
      if (fr == 0 && tx_ready) fr = k;
      if (rr == 0 && rx_ready == ALL) rr = k;
    end
    total++; if (fa < 70 || fa > 72) begin bad++; $display("FAIL rp_tx_ana_fall: got %0d expected 70..72", fa); end
    total++; if (fr < 91 || fr > 93) begin bad++; $display("FAIL rp_tx_ready: got %0d expected 91..93", fr); end
    total++; if (rr < 490 || rr > 494) begin bad++; $display("FAIL rp_rx_ready: got %0d expected 490..494", rr); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_cal_busy();
    test_lock_loss();
    test_timeout();
    test_rx_req();
    test_tx_req();
    test_pll_drop();
    test_reset_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
